// File: rtl/shift_seq_if.sv
// Request/response handshake bundle for the multi-cycle shift controller.
// The master side issues shift requests and consumes results.
interface shift_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_dir;
  logic        req_al;
  logic [31:0] req_a;
  logic [4:0]  req_shamt;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_dir, req_al, req_a, req_shamt, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_dir, req_al, req_a, req_shamt, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle SLL/SRL/SRA controller: applies at most STEP bit positions per cycle
// and holds the result on a valid/ready response port until consumed.
module shift_seq #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kill,
  shift_seq_if.slave  bus,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] STEP5 = 5'(STEP);

  state_t      state, state_nxt;
  logic [31:0] acc, acc_nxt;
  logic [4:0]  remaining, rem_nxt;
  logic        dir_q, dir_nxt;
  logic        al_q, al_nxt;

  logic [4:0]  step;
  logic        fill;
  logic [63:0] wide;
  logic [63:0] wide_sh;
  logic [31:0] shifted;

  always_comb begin
    step = (remaining < STEP5) ? remaining : STEP5;
  end

  // Only STEP+1 tap positions exist; fill bit comes from acc[31], which an
  // arithmetic right step never changes, so per-step sign fill stays correct.
  always_comb begin
    fill    = al_q & acc[31];
    wide    = {{32{fill}}, acc};
    wide_sh = wide;
    shifted = acc;
    for (int unsigned i = 1; i <= STEP; i++) begin
      if (step == 5'(i)) begin
        wide_sh = wide >> i;
        shifted = dir_q ? wide_sh[31:0] : (acc << i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = remaining;
    dir_nxt   = dir_q;
    al_nxt    = al_q;
    if (kill) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            acc_nxt   = bus.req_a;
            rem_nxt   = bus.req_shamt;
            dir_nxt   = bus.req_dir;
            al_nxt    = bus.req_al;
            state_nxt = (bus.req_shamt == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          acc_nxt = shifted;
          rem_nxt = remaining - step;
          if (remaining == step) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          rem_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
      al_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= rem_nxt;
      dir_q     <= dir_nxt;
      al_q      <= al_nxt;
    end
  end

  assign bus.req_ready  = rst_n & (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_data  = acc;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed-vector bench for shift_seq: result/latency table plus hand-written
// backpressure, kill, reset and STEP=16 sequences, and a modelled random sweep.
module tb_shift_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic kill;
  logic kill16;
  logic busy;
  logic busy16;

  shift_seq_if bus();
  shift_seq_if b16();

  shift_seq #(.STEP(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kill (kill),
    .bus  (bus.slave),
    .busy (busy)
  );

  shift_seq #(.STEP(16)) dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .kill (kill16),
    .bus  (b16.slave),
    .busy (busy16)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        dir;
    logic        al;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic d, input logic al,
                                        input logic [31:0] a, input logic [4:0] sh);
    if (!d) return a << sh;
    if (al) return 32'($signed(a) >>> sh);
    return a >> sh;
  endfunction

  task automatic run_req(input logic d, input logic al, input logic [31:0] a,
                         input logic [4:0] sh, input int hold,
                         output logic [31:0] data, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_dir   = d;
    bus.req_al    = al;
    bus.req_a     = a;
    bus.req_shamt = sh;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    data = bus.resp_data;
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] data;
    logic [31:0] held;
    int          lat;
    int          n;
    logic        rose;

    vecs[0]  = '{1'b1, 1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 8};
    vecs[1]  = '{1'b1, 1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001, 8};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0001, 5'd0,  32'h0000_0001, 0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0001, 5'd5,  32'h0000_0020, 2};
    vecs[4]  = '{1'b0, 1'b0, 32'h1234_5678, 5'd4,  32'h2345_6780, 1};
    vecs[5]  = '{1'b1, 1'b1, 32'h8000_0000, 5'd1,  32'hC000_0000, 1};
    vecs[6]  = '{1'b1, 1'b1, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 8};
    vecs[7]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 8};
    vecs[8]  = '{1'b1, 1'b0, 32'hF0F0_F0F0, 5'd8,  32'h00F0_F0F0, 2};
    vecs[9]  = '{1'b1, 1'b1, 32'hF0F0_F0F0, 5'd8,  32'hFFF0_F0F0, 2};
    vecs[10] = '{1'b0, 1'b0, 32'hA5A5_A5A5, 5'd16, 32'hA5A5_0000, 4};
    vecs[11] = '{1'b1, 1'b1, 32'h8000_0000, 5'd0,  32'h8000_0000, 0};
    vecs[12] = '{1'b1, 1'b1, 32'h4000_0000, 5'd30, 32'h0000_0001, 8};

    rst_n = 1'b0;
    kill = 1'b0;
    kill16 = 1'b0;
    bus.req_valid = 1'b0; bus.req_dir = 1'b0; bus.req_al = 1'b0;
    bus.req_a = '0; bus.req_shamt = '0; bus.resp_ready = 1'b0;
    b16.req_valid = 1'b0; b16.req_dir = 1'b0; b16.req_al = 1'b0;
    b16.req_a = '0; b16.req_shamt = '0; b16.resp_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", {31'b0, bus.req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i].dir, vecs[i].al, vecs[i].a, vecs[i].sh, 0, data, lat);
      chk($sformatf("vec%0d_data", i), data, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // backpressure in DONE with a second request waiting; fields change mid-flight
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_dir = 1'b0; bus.req_al = 1'b0;
    bus.req_a = 32'h0000_00FF; bus.req_shamt = 5'd3;
    @(negedge clk);
    bus.req_dir = 1'b1; bus.req_al = 1'b1;
    bus.req_a = 32'h8000_0010; bus.req_shamt = 5'd4;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_first_lat", 32'(n), 32'd1);
    chk("bp_first_data", bus.resp_data, 32'h0000_07F8);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_data", bus.resp_data, 32'h0000_07F8);
      chk("bp_hold_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("bp_hold_busy", {31'b0, busy}, 32'd1);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("bp_idle_busy", {31'b0, busy}, 32'd0);
    chk("bp_idle_ready", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second_lat", 32'(n), 32'd1);
    chk("bp_second_data", bus.resp_data, 32'hF800_0001);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;

    // kill in the second BUSY cycle
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_dir = 1'b1; bus.req_al = 1'b1;
    bus.req_a = 32'hF000_0000; bus.req_shamt = 5'd20;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("kill_ready", {31'b0, bus.req_ready}, 32'd1);
    rose = 1'b0;
    repeat (8) begin
      @(negedge clk);
      rose = rose | bus.resp_valid;
    end
    chk("kill_no_resp", {31'b0, rose}, 32'd0);
    run_req(1'b0, 1'b0, 32'h1234_5678, 5'd4, 0, data, lat);
    chk("post_kill_data", data, 32'h2345_6780);
    chk("post_kill_lat", 32'(lat), 32'd1);

    // request in the same edge as kill is dropped
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_dir = 1'b0; bus.req_shamt = 5'd3;
    kill = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    kill = 1'b0;
    chk("kill_same_edge_busy", {31'b0, busy}, 32'd0);

    // kill while DONE drops the response
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_dir = 1'b0; bus.req_a = 32'h1; bus.req_shamt = 5'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("done_before_kill", {31'b0, bus.resp_valid}, 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_done_valid", {31'b0, bus.resp_valid}, 32'd0);

    // reset mid-BUSY
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_dir = 1'b0;
    bus.req_a = 32'hDEAD_BEEF; bus.req_shamt = 5'd20;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rstmid_data", bus.resp_data, 32'd0);
    chk("rstmid_ready_low", {31'b0, bus.req_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rstmid_ready_high", {31'b0, bus.req_ready}, 32'd1);

    // STEP=16, shamt=31: two BUSY cycles
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b16.req_valid = 1'b1; b16.req_dir = 1'b1; b16.req_al = k[0];
      b16.req_a = 32'h8000_0000; b16.req_shamt = 5'd31;
      @(negedge clk);
      b16.req_valid = 1'b0;
      n = 0;
      while (!b16.resp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("s16_lat", 32'(n), 32'd2);
      chk("s16_data", b16.resp_data, (k == 0) ? 32'h0000_0001 : 32'hFFFF_FFFF);
      b16.resp_ready = 1'b1;
      @(negedge clk);
      b16.resp_ready = 1'b0;
      chk("s16_idle", {31'b0, busy16}, 32'd0);
    end

    // random sweep against the single-cycle model
    for (int r = 0; r < 300; r++) begin
      logic        d, al;
      logic [31:0] a;
      logic [4:0]  sh;
      d  = 1'($urandom_range(0, 1));
      al = 1'($urandom_range(0, 1));
      a  = $urandom;
      sh = 5'($urandom_range(0, 31));
      run_req(d, al, a, sh, int'($urandom_range(0, 3)), data, lat);
      chk("rand_data", data, model(d, al, a, sh));
      chk("rand_lat", 32'(lat), 32'((int'(sh) + 3) / 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
